// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and command-to-ALU opcode mapping for alu_wide_sequencer.
// Build option COMPARE_EN: when defined, the signed compares 0111/1011 execute; otherwise they are rejected.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_RSV3   = 4'b0011;
  localparam logic [3:0] OP_AND_NB = 4'b0100;
  localparam logic [3:0] OP_OR_NB  = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_SLT    = 4'b0111;
  localparam logic [3:0] OP_AND_NA = 4'b1000;
  localparam logic [3:0] OP_OR_NA  = 4'b1001;
  localparam logic [3:0] OP_RSUB   = 4'b1010;
  localparam logic [3:0] OP_SGT    = 4'b1011;
  localparam logic [3:0] OP_NOR    = 4'b1100;
  localparam logic [3:0] OP_NAND   = 4'b1101;
  localparam logic [3:0] OP_RSVE   = 4'b1110;
  localparam logic [3:0] OP_RSVF   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [3:0] issue;
    logic       reject;
  } op_map_t;

  // Compares run as a byte-wise subtract; the slt bit is derived from the top byte afterwards.
  function automatic op_map_t seq_map_op(input logic [3:0] op);
    op_map_t m;
    m.issue  = op;
    m.reject = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_AND_NB, OP_OR_NB, OP_SUB,
      OP_AND_NA, OP_OR_NA, OP_RSUB, OP_NOR, OP_NAND: m.issue = op;
`ifdef COMPARE_EN
      OP_SLT: m.issue = OP_SUB;
      OP_SGT: m.issue = OP_RSUB;
`else
      OP_SLT, OP_SGT: begin
        m.issue  = OP_AND;
        m.reject = 1'b1;
      end
`endif
      OP_RSV3, OP_RSVE, OP_RSVF: begin
        m.issue  = OP_AND;
        m.reject = 1'b1;
      end
      default: begin
        m.issue  = OP_AND;
        m.reject = 1'b1;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Drives a shared 8-bit ALU one byte per cycle (LSB first) to execute NBYTES-wide operations.
// Build option COMPARE_EN enables the signed compare opcodes 0111/1011.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
// valid never depends on ready, and the offering side holds its payload stable until the transfer.
module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_x,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [3:0]       alu_cont,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  input  logic [7:0]       alu_x,
  input  logic             alu_zero,
  input  logic             alu_cout,
  output seq_state_e       dbg_state
);

  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  seq_state_e     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [3:0]     op_q, op_d;
  logic [3:0]     issue_q, issue_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic           zero_acc_q, zero_acc_d;
  logic [W-1:0]   rsp_x_q, rsp_x_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_err_q, rsp_err_d;

  op_map_t        map;
  logic [W-1:0]   x_full;
  logic           a7, b7, x7;
`ifdef COMPARE_EN
  logic           slt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      op_q       <= '0;
      issue_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      rsp_x_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      op_q       <= op_d;
      issue_q    <= issue_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      zero_acc_q <= zero_acc_d;
      rsp_x_q    <= rsp_x_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    map        = seq_map_op(cmd_op);
    x_full     = {alu_x, res_q[W-9:0]};
    a7         = a_q[W-1];
    b7         = b_q[W-1];
    x7         = alu_x[7];
`ifdef COMPARE_EN
    slt        = (a7 ^ b7) ? ((op_q == OP_SLT) ? a7 : b7) : x7;
`endif
    state_d    = state_q;
    k_d        = k_q;
    op_d       = op_q;
    issue_d    = issue_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    zero_acc_d = zero_acc_q;
    rsp_x_d    = rsp_x_q;
    rsp_zero_d = rsp_zero_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_cont   = 4'b0000;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_cin    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d       = cmd_op;
          issue_d    = map.issue;
          a_d        = cmd_a;
          b_d        = cmd_b;
          k_d        = '0;
          carry_d    = 1'b0;
          zero_acc_d = 1'b1;
          res_d      = '0;
          rsp_x_d    = '0;
          rsp_zero_d = 1'b0;
          rsp_cout_d = 1'b0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = map.reject;
          state_d    = map.reject ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        alu_cont   = issue_q;
        alu_a      = a_q[8*k_q +: 8];
        alu_b      = b_q[8*k_q +: 8];
        alu_cin    = carry_q;
        res_d[8*k_q +: 8] = alu_x;
        carry_d    = alu_cout;
        zero_acc_d = zero_acc_q & alu_zero;
        if (k_q == K_LAST) begin
          // Last byte: ALU outputs are final this cycle, so build the response directly from them.
          rsp_x_d    = x_full;
          rsp_zero_d = zero_acc_q & alu_zero;
          rsp_cout_d = alu_cout;
          case (op_q)
            OP_ADD:  rsp_ovf_d = (a7 == b7) && (x7 != a7);
            OP_SUB:  rsp_ovf_d = (a7 != b7) && (x7 != a7);
            OP_RSUB: rsp_ovf_d = (a7 != b7) && (x7 != b7);
            default: rsp_ovf_d = 1'b0;
          endcase
`ifdef COMPARE_EN
          if (op_q == OP_SLT || op_q == OP_SGT) begin
            rsp_x_d    = {{(W-1){1'b0}}, slt};
            rsp_zero_d = !slt;
          end
`endif
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_x     = rsp_x_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (NBYTES=4) driving a behavioural ALU_8bit model.
// Compare vectors follow the COMPARE_EN build option.
module tb_alu_wide_sequencer;
  import alu_seq_pkg::*;

  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = 4'b0000;
  logic [W-1:0]   cmd_a = '0;
  logic [W-1:0]   cmd_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_x;
  logic           rsp_zero, rsp_cout, rsp_ovf, rsp_err;
  logic [3:0]     alu_cont;
  logic [7:0]     alu_a, alu_b, alu_x;
  logic           alu_cin, alu_zero, alu_cout;
  seq_state_e     dbg_state;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x),
    .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_cont(alu_cont), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_x(alu_x), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .dbg_state(dbg_state)
  );

  ALU_8bit u_alu (
    .ALU_cont(alu_cont), .A(alu_a), .B(alu_b), .Cin(alu_cin),
    .X(alu_x), .Zero(alu_zero), .Cout(alu_cout)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, wait for the response, check it, optionally hold rsp_ready low, then hand off.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ex, input logic ez, input logic ec,
                        input logic eo, input logic ee, input int elat, input int hold);
    int cyc;
    logic alu_busy;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, ".cmd_ready"}, W'(cmd_ready), W'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cyc = 0;
    alu_busy = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (alu_cont != 4'b0000 || alu_a != 8'h00 || alu_b != 8'h00 || alu_cin) alu_busy = 1'b1;
    end while (!rsp_valid && cyc < 20);
    check_eq({name, ".latency"}, W'(cyc), W'(elat));
    check_eq({name, ".x"},    rsp_x, ex);
    check_eq({name, ".zero"}, W'(rsp_zero), W'(ez));
    check_eq({name, ".cout"}, W'(rsp_cout), W'(ec));
    check_eq({name, ".ovf"},  W'(rsp_ovf), W'(eo));
    check_eq({name, ".err"},  W'(rsp_err), W'(ee));
    check_eq({name, ".busy_ready"}, W'(cmd_ready), W'(0));
    if (ee) check_eq({name, ".alu_idle"}, W'(alu_busy), W'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({name, ".hold_valid"}, W'(rsp_valid), W'(1));
      check_eq({name, ".hold_x"}, rsp_x, ex);
      check_eq({name, ".hold_ready"}, W'(cmd_ready), W'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq({name, ".post_valid"}, W'(rsp_valid), W'(0));
    check_eq({name, ".post_ready"}, W'(cmd_ready), W'(1));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset.cmd_ready", W'(cmd_ready), W'(1));
    check_eq("reset.rsp_valid", W'(rsp_valid), W'(0));
    check_eq("reset.rsp_x", rsp_x, '0);
    check_eq("reset.flags", W'({rsp_zero, rsp_cout, rsp_ovf, rsp_err}), W'(0));
    check_eq("reset.alu", W'({alu_cont, alu_a, alu_b, alu_cin}), W'(0));

    //     name      op       A             B             X             z     c     o     e     lat hold
    run_op("add",    4'b0010, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("sub0",   4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
    run_op("subovf", 4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 5, 0);
    run_op("rsub",   4'b1010, 32'h00000001, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("addwrap",4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 5, 0);
    run_op("addovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 5, 0);
    run_op("or",     4'b0001, 32'h12345678, 32'h0F0F0000, 32'h1F3F5678, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("nand",   4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("and_bp", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3);
    run_op("rsv3",   4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op("rsvf",   4'b1111, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
`ifdef COMPARE_EN
    run_op("slt",    4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("sgt",    4'b1011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 5, 0);
`else
    run_op("slt",    4'b0111, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op("sgt",    4'b1011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
`endif

    // Reset while byte 2 is on the ALU: the command must vanish without a response.
    cmd_valid = 1'b1;
    cmd_op    = 4'b0010;
    cmd_a     = 32'h11223344;
    cmd_b     = 32'h01010101;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rstrun.byte2_a", W'(alu_a), W'(8'h22));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstrun.cmd_ready", W'(cmd_ready), W'(1));
    check_eq("rstrun.alu_cont", W'(alu_cont), W'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check_eq("rstrun.no_rsp", W'(seen), W'(0));
    run_op("add_after_rst", 4'b0010, 32'h12345678, 32'h11111111, 32'h23456789,
           1'b0, 1'b0, 1'b0, 1'b0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// Behavioural model of the external 8-bit ALU: AND/OR with optional operand inversion,
// add with carry, and subtracts (A-B-Cin / B-A-Cin) reporting borrow on Cout.
module ALU_8bit (
  input  logic [3:0] ALU_cont,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] X,
  output logic       Zero,
  output logic       Cout
);
  logic [8:0] t;

  always_comb begin
    t    = 9'd0;
    X    = 8'h00;
    Cout = 1'b0;
    case (ALU_cont)
      4'b0000: X = A & B;
      4'b0001: X = A | B;
      4'b0100: X = A & ~B;
      4'b0101: X = A | ~B;
      4'b1000: X = ~A & B;
      4'b1001: X = ~A | B;
      4'b1100: X = ~A & ~B;
      4'b1101: X = ~A | ~B;
      4'b0010: begin
        t    = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
        X    = t[7:0];
        Cout = t[8];
      end
      4'b0110: begin
        t    = {1'b0, A} - {1'b0, B} - {8'd0, Cin};
        X    = t[7:0];
        Cout = t[8];
      end
      4'b1010: begin
        t    = {1'b0, B} - {1'b0, A} - {8'd0, Cin};
        X    = t[7:0];
        Cout = t[8];
      end
      default: begin
        X    = 8'h00;
        Cout = 1'b0;
      end
    endcase
    Zero = (X == 8'h00);
  end
endmodule
